alu_multicycle: RTL and testbench

Parametrised, handshaked successor to the datapath's combinational ALU. Accepts one operation at a time over a valid/ready interface. Single-cycle logic and arithmetic ops are registered; shifts and (optionally) multiply iterate in a small state machine. Sits between the register-read stage and writeback, so the pipeline can stall on long ops instead of timing a barrel shifter or multiplier in one cycle.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_mul_iter.sv | 50 +++++
 rtl/alu_multicycle.sv | 177 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and decode definitions for the multicycle ALU.
// Opcode 1010 (MUL) is only legal when ALU_MUL_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    K_SINGLE,
    K_SHIFT,
    K_MUL,
    K_ILLEGAL
  } kind_e;

  function automatic kind_e op_kind(
    input logic [3:0] op,
    input logic       mul_en
  );
    kind_e k;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XOR,
      OP_SUB, OP_SLT, OP_SLTU: k = K_SINGLE;
      OP_SLL, OP_SRL, OP_SRA:  k = K_SHIFT;
      OP_MUL: k = mul_en ? K_MUL : K_ILLEGAL;
      default: k = K_ILLEGAL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles.
// done is high in the final cycle; product is valid while done is high.
module alu_mul_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] mc;
  logic [XLEN-1:0] mp;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_n;
  logic [CW-1:0]   cnt;
  logic            run;

  assign acc_n   = mp[0] ? acc + mc : acc;
  assign done    = run && (cnt == CW'(1));
  assign product = acc_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      mc  <= '0;
      mp  <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      mc  <= a;
      mp  <= b;
      acc <= '0;
      cnt <= CW'(XLEN);
      run <= 1'b1;
    end else if (run) begin
      acc <= acc_n;
      mc  <= {mc[XLEN-2:0], 1'b0};
      mp  <= {1'b0, mp[XLEN-1:1]};
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle ops registered, shifts iterate 1 bit/cycle.
// Define ALU_MUL_EN to add the iterative multiplier (opcode 1010).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic [3:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
`ifdef ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  state_e          state;
  state_e          state_n;
  logic [3:0]      op_q;
  logic [XLEN-1:0] res;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            busy_done;
  kind_e           kind;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] single;
  logic [XLEN-1:0] shifted;

  assign accept     = in_valid & in_ready;
  assign kind       = op_kind(alu_control, MUL_EN);
  assign shamt      = y[SW-1:0];
  assign alu_result = res;

`ifdef ALU_MUL_EN
  logic            mul_done;
  logic [XLEN-1:0] mul_p;

  alu_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (kind == K_MUL)),
    .a       (x),
    .b       (y),
    .done    (mul_done),
    .product (mul_p)
  );

  assign busy_done = (op_q == OP_MUL) ? mul_done
                                      : (cnt == CW'(1));
`else
  assign busy_done = (cnt == CW'(1));
`endif

  always_comb begin
    single = '0;
    case (alu_control)
      OP_AND:  single = x & y;
      OP_OR:   single = x | y;
      OP_XOR:  single = x ^ y;
      OP_ADD:  single = x + y;
      OP_SUB:  single = x - y;
      OP_SLT:  single = XLEN'($signed(x) < $signed(y));
      OP_SLTU: single = XLEN'(x < y);
      default: single = '0;
    endcase
  end

  always_comb begin
    shifted = {res[XLEN-1], res[XLEN-1:1]};
    case (op_q)
      OP_SLL:  shifted = {res[XLEN-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, res[XLEN-1:1]};
      default: shifted = {res[XLEN-1], res[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (accept) begin
          if ((kind == K_MUL) ||
              (kind == K_SHIFT && shamt != '0))
            state_n = S_BUSY;
          else
            state_n = S_DONE;
        end
      S_BUSY:
        if (busy_done) state_n = S_DONE;
      S_DONE:
        if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) && !rst;
    out_valid = (state == S_DONE);
  end

  // zero tracks res on every update; it only matters once DONE is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      res     <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (accept) begin
            op_q    <= alu_control;
            illegal <= (kind == K_ILLEGAL);
            cnt     <= '0;
            case (kind)
              K_SHIFT: begin
                res  <= x;
                zero <= (x == '0);
                cnt  <= CW'(shamt);
              end
              K_MUL: begin
                res  <= '0;
                zero <= 1'b1;
                cnt  <= CW'(XLEN);
              end
              K_ILLEGAL: begin
                res  <= '0;
                zero <= 1'b1;
              end
              default: begin
                res  <= single;
                zero <= (single == '0);
              end
            endcase
          end
        S_BUSY: begin
          cnt <= cnt - CW'(1);
`ifdef ALU_MUL_EN
          if (op_q == OP_MUL) begin
            if (mul_done) begin
              res  <= mul_p;
              zero <= (mul_p == '0);
            end
          end else begin
            res  <= shifted;
            zero <= (shifted == '0);
          end
`else
          res  <= shifted;
          zero <= (shifted == '0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (XLEN=64).
// Build with ALU_MUL_EN defined to exercise the multiplier path.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x = '0;
  logic [63:0] y = '0;
  logic [3:0]  alu_control = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] alu_result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.XLEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_result  (alu_result),
    .zero        (zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] c, output int lat);
    int w;
    @(negedge clk);
    x = a;
    y = b;
    alu_control = c;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] c,
                        input logic [63:0] er, input logic ez,
                        input logic ei, input int el);
    int lat;
    issue(a, b, c, lat);
    checks++;
    if (lat !== el || alu_result !== er || zero !== ez || illegal !== ei) begin
      errors++;
      $display("FAIL %s: got res=%h z=%b ill=%b lat=%0d, want res=%h z=%b ill=%b lat=%0d",
               name, alu_result, zero, illegal, lat, er, ez, ei, el);
    end
    take();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== 64'd0 || zero !== 1'b0 ||
        illegal !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ov=%b res=%h z=%b ill=%b rdy=%b, want 0 0 0 0 0",
               out_valid, alu_result, zero, illegal, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    run_op("add", 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 1'b0, 1);
    run_op("sub_zero", 64'h10, 64'h10, 4'b0110, 64'd0, 1'b1, 1'b0, 1);
    run_op("sub_wrap", 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);
    run_op("and", 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000, 1'b0, 1'b0, 1);
    run_op("or", 64'hF0F0, 64'hFF00, 4'b0001, 64'hFFF0, 1'b0, 1'b0, 1);
    run_op("xor", 64'hF0F0, 64'hFF00, 4'b0011, 64'h0FF0, 1'b0, 1'b0, 1);
  endtask

  task automatic test_shift();
    run_op("sra4", 64'h8000_0000_0000_0000, 64'd4, 4'b0111,
           64'hF800_0000_0000_0000, 1'b0, 1'b0, 5);
    run_op("sll0", 64'h1234, 64'd0, 4'b0100, 64'h1234, 1'b0, 1'b0, 1);
    run_op("sll3", 64'd1, 64'd3, 4'b0100, 64'd8, 1'b0, 1'b0, 4);
    run_op("sll_hiy", 64'd1, 64'h104, 4'b0100, 64'd16, 1'b0, 1'b0, 5);
    run_op("srl7", 64'h80, 64'd7, 4'b0101, 64'd1, 1'b0, 1'b0, 8);
    run_op("srl63", 64'h8000_0000_0000_0000, 64'd63, 4'b0101, 64'd1, 1'b0, 1'b0, 64);
    run_op("srl_out", 64'h1, 64'd1, 4'b0101, 64'd0, 1'b1, 1'b0, 2);
  endtask

  task automatic test_illegal_slt();
    run_op("illegal_f", 64'd9, 64'd3, 4'b1111, 64'd0, 1'b1, 1'b1, 1);
    run_op("slt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000, 64'd1, 1'b0, 1'b0, 1);
    run_op("sltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 64'd0, 1'b1, 1'b0, 1);
  endtask

  task automatic test_mul();
`ifdef ALU_MUL_EN
    run_op("mul", 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010,
           64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0, 65);
    run_op("mul_big", 64'h1_0000_0001, 64'h1_0000_0001, 4'b1010,
           64'h2_0000_0001, 1'b0, 1'b0, 65);
`else
    run_op("mul_off", 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010,
           64'd0, 1'b1, 1'b1, 1);
`endif
  endtask

  task automatic test_hold();
    int lat;
    issue(64'd1, 64'd2, 4'b0010, lat);
    @(negedge clk);
    x = 64'hA;
    y = 64'h6;
    alu_control = 4'b0011;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 64'd3 || zero !== 1'b0 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: ov=%b res=%h z=%b rdy=%b, want 1 3 0 0",
                 i, out_valid, alu_result, zero, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 64'hC) begin
      errors++;
      $display("FAIL hold_next: ov=%b res=%h, want 1 c", out_valid, alu_result);
    end
    take();
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    x = 64'hFFFF_0000_FFFF_0000;
    y = 64'd40;
    alu_control = 4'b0101;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold: rdy=%b ov=%b, want 0 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: in_ready=%b want 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_noresult: out_valid cycles=%0d want 0", seen);
    end
    run_op("add_after_rst", 64'd100, 64'd23, 4'b0010, 64'd123, 1'b0, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_illegal_slt();
    test_mul();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
